// File: rtl/axi_lite_rd_arbiter_pkg.sv
// Shared definitions for the AXI-Lite read arbiter:
//   - arb_state_t : arbiter FSM state encoding (IDLE -> AR -> R -> IDLE)
//   - RESP_*      : AXI read response codes
//   - gw_f        : width of a requester index, never narrower than 1 bit
package axi_lite_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int gw_f(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axi_lite_rd_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : index of the previous winner; the search starts at ptr+1
//   any : at least one request is present
//   idx : winning requester index (0 when no request is present)
module rr_pick #(
   parameter int N  = 2,
   parameter int GW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic          any,
   output logic [GW-1:0] idx
);

   localparam logic [GW:0] N_W = (GW + 1)'(N);

   logic [GW:0]   sum_s;
   logic [GW-1:0] cand_s;

   // Scan candidates from the farthest to the nearest so the nearest
   // requester after ptr (wrapping modulo N) is the last one written.
   always_comb begin
      any    = |req;
      idx    = {GW{1'b0}};
      sum_s  = {(GW + 1){1'b0}};
      cand_s = {GW{1'b0}};
      for (int k = N; k >= 1; k--) begin
         // ptr < N and k <= N, so one conditional subtraction wraps the sum
         sum_s  = {1'b0, ptr} + (GW + 1)'(k);
         cand_s = GW'((sum_s >= N_W) ? (sum_s - N_W) : sum_s);
         if (req[cand_s]) begin
            idx = cand_s;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// AXI-Lite read-channel arbiter: N requesters share one downstream slave,
// one transaction outstanding at a time, round-robin fairness.
//   axi_aclk/axi_arstn       : clock, asynchronous active-low reset
//   s_ar*  (per requester)   : upstream AR channels, packed slice i = requester i
//   s_r*                     : upstream R channels; rdata/rresp are broadcast
//   m_ar*, m_r*              : shared downstream AXI-Lite read channel
//   grant                    : index of the current/last owner
//   busy                     : a transaction is in flight
module axi_lite_rd_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter  int N      = 2,
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int GW     = gw_f(N)
) (
   input  logic                axi_aclk,
   input  logic                axi_arstn,
   input  logic [N-1:0]        s_arvalid,
   output logic [N-1:0]        s_arready,
   input  logic [N*ADDR_W-1:0] s_araddr,
   input  logic [N*3-1:0]      s_arprot,
   output logic [N-1:0]        s_rvalid,
   input  logic [N-1:0]        s_rready,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [2:0]          m_arprot,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   output logic [GW-1:0]       grant,
   output logic                busy
);

   arb_state_t        state_r;
   logic [GW-1:0]     ptr_r;
   logic [GW-1:0]     grant_r;
   logic [ADDR_W-1:0] addr_r;
   logic [2:0]        prot_r;
   logic              arvalid_r;
   logic              busy_r;

   logic              pick_any_s;
   logic [GW-1:0]     pick_idx_s;

   rr_pick #(
      .N  (N),
      .GW (GW)
   ) u_rr_pick (
      .req (s_arvalid),
      .ptr (ptr_r),
      .any (pick_any_s),
      .idx (pick_idx_s)
   );

   assign m_arvalid = arvalid_r;
   assign m_araddr  = addr_r;
   assign m_arprot  = prot_r;
   assign grant     = grant_r;
   assign busy      = busy_r;
   // Data and response are broadcast; only the owner sees s_rvalid.
   assign s_rdata   = m_rdata;
   assign s_rresp   = m_rresp;

   // Steer AR acceptance and the R handshake between owner and slave.
   always_comb begin
      s_arready = {N{1'b0}};
      s_rvalid  = {N{1'b0}};
      m_rready  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               s_arready[pick_idx_s] = 1'b1;
            end else begin
               s_arready = {N{1'b0}};
            end
         end
         ST_AR: begin
            m_rready = 1'b0;
         end
         ST_R: begin
            s_rvalid[grant_r] = m_rvalid;
            m_rready          = s_rready[grant_r];
         end
         default: begin
            m_rready = 1'b0;
         end
      endcase
   end

   // Arbiter FSM with registered downstream AR request and status outputs.
   always_ff @(posedge axi_aclk or negedge axi_arstn) begin
      if (!axi_arstn) begin
         state_r   <= ST_IDLE;
         ptr_r     <= GW'(N - 1);
         grant_r   <= {GW{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         prot_r    <= 3'b000;
         arvalid_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // The winner always sees s_arready, so any request is a handshake.
               if (pick_any_s) begin
                  addr_r    <= s_araddr[int'(pick_idx_s) * ADDR_W +: ADDR_W];
                  prot_r    <= s_arprot[int'(pick_idx_s) * 3 +: 3];
                  grant_r   <= pick_idx_s;
                  arvalid_r <= 1'b1;
                  busy_r    <= 1'b1;
                  state_r   <= ST_AR;
               end
            end
            ST_AR: begin
               if (m_arready) begin
                  arvalid_r <= 1'b0;
                  state_r   <= ST_R;
               end
            end
            ST_R: begin
               if (m_rvalid && s_rready[grant_r]) begin
                  ptr_r   <= grant_r;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               arvalid_r <= 1'b0;
               busy_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for axi_lite_rd_arbiter (N=2, 32-bit address/data).
// Directed scenarios followed by a randomized run checked against a
// transaction-level round-robin reference model.
module tb_axi_lite_rd_arbiter;
   import axi_lite_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            axi_arstn;
   logic [N-1:0]    s_arvalid;
   logic [N-1:0]    s_arready;
   logic [N*AW-1:0] s_araddr;
   logic [N*3-1:0]  s_arprot;
   logic [N-1:0]    s_rvalid;
   logic [N-1:0]    s_rready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            m_arvalid;
   logic            m_arready;
   logic [AW-1:0]   m_araddr;
   logic [2:0]      m_arprot;
   logic            m_rvalid;
   logic            m_rready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic [0:0]      grant;
   logic            busy;

   int total = 0;
   int bad   = 0;

   axi_lite_rd_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .axi_aclk (clk),       .axi_arstn (axi_arstn),
      .s_arvalid(s_arvalid), .s_arready (s_arready),
      .s_araddr (s_araddr),  .s_arprot  (s_arprot),
      .s_rvalid (s_rvalid),  .s_rready  (s_rready),
      .s_rdata  (s_rdata),   .s_rresp   (s_rresp),
      .m_arvalid(m_arvalid), .m_arready (m_arready),
      .m_araddr (m_araddr),  .m_arprot  (m_arprot),
      .m_rvalid (m_rvalid),  .m_rready  (m_rready),
      .m_rdata  (m_rdata),   .m_rresp   (m_rresp),
      .grant    (grant),     .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every task starts just after a falling edge: drive, wait #1, check,
   // then advance to the next falling edge.
   task automatic drive_quiet();
      s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_rready = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = RESP_OKAY;
   endtask

   task automatic do_reset();
      axi_arstn = 1'b0;
      drive_quiet();
      repeat (3) @(posedge clk);
      @(negedge clk);
      axi_arstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant); end
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", m_arvalid); end
      total++; if (m_araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr: got %h want 0", m_araddr); end
      total++; if (s_arready !== 2'b00) begin bad++; $display("FAIL reset_arready: got %b want 00", s_arready); end
      total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL reset_rready: got %b want 0", m_rready); end
      @(negedge clk);
   endtask

   task automatic test_single();
      s_arvalid = 2'b01; s_araddr[31:0] = 32'h0000_0010; s_arprot[2:0] = 3'b010;
      #1;
      total++; if (s_arready !== 2'b01) begin bad++; $display("FAIL single_arready: got %b want 01", s_arready); end
      @(negedge clk);
      s_arvalid = 2'b00; m_arready = 1'b1;
      #1;
      total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %b want 1", m_arvalid); end
      total++; if (m_araddr !== 32'h0000_0010) begin bad++; $display("FAIL single_araddr: got %h want 00000010", m_araddr); end
      total++; if (m_arprot !== 3'b010) begin bad++; $display("FAIL single_arprot: got %b want 010", m_arprot); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL single_grant: got %0d want 0", grant); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; s_rready = 2'b01;
      #1;
      total++; if (s_rvalid !== 2'b01) begin bad++; $display("FAIL single_rvalid: got %b want 01", s_rvalid); end
      total++; if (s_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", s_rdata); end
      total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL single_rready: got %b want 1", m_rready); end
      @(negedge clk);
      drive_quiet();
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int exp_seq [4] = '{0, 1, 0, 1};
      logic [1:0] exp_oh;
      do_reset();
      s_arvalid = 2'b11; s_araddr = {32'h0000_0200, 32'h0000_0100};
      m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0000; s_rready = 2'b11;
      for (int t = 0; t < 4; t++) begin
         exp_oh = 2'b01 << exp_seq[t];
         #1;
         total++; if (s_arready !== exp_oh) begin bad++; $display("FAIL cont_arready[%0d]: got %b want %b", t, s_arready, exp_oh); end
         total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL cont_idle_rready[%0d]: got %b want 0", t, m_rready); end
         @(negedge clk); #1;
         total++; if (grant !== 1'(exp_seq[t])) begin bad++; $display("FAIL cont_grant[%0d]: got %0d want %0d", t, grant, exp_seq[t]); end
         total++; if (m_araddr !== (exp_seq[t] == 1 ? 32'h0000_0200 : 32'h0000_0100)) begin bad++; $display("FAIL cont_araddr[%0d]: got %h", t, m_araddr); end
         @(negedge clk); #1;
         total++; if (s_rvalid !== exp_oh) begin bad++; $display("FAIL cont_rvalid[%0d]: got %b want %b", t, s_rvalid, exp_oh); end
         @(negedge clk);
      end
      drive_quiet();
   endtask

   task automatic test_backpressure();
      s_arvalid = 2'b10; s_araddr[63:32] = 32'h0000_2000; s_arprot[5:3] = 3'b101;
      #1;
      total++; if (s_arready !== 2'b10) begin bad++; $display("FAIL bp_arready: got %b want 10", s_arready); end
      @(negedge clk);
      s_arvalid = 2'b00; m_arready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         m_arready = (i == 5);
         #1;
         total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL bp_arvalid[%0d]: got %b want 1", i, m_arvalid); end
         total++; if (m_araddr !== 32'h0000_2000) begin bad++; $display("FAIL bp_araddr[%0d]: got %h want 00002000", i, m_araddr); end
         total++; if (s_rvalid !== 2'b00) begin bad++; $display("FAIL bp_ar_rvalid[%0d]: got %b want 00", i, s_rvalid); end
         @(negedge clk);
      end
      m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678; s_rready = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (s_rvalid !== 2'b10) begin bad++; $display("FAIL bp_rvalid[%0d]: got %b want 10", i, s_rvalid); end
         total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL bp_rready[%0d]: got %b want 0", i, m_rready); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
         @(negedge clk);
      end
      s_rready = 2'b10;
      #1;
      total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL bp_rready_rel: got %b want 1", m_rready); end
      total++; if (s_rdata !== 32'h1234_5678) begin bad++; $display("FAIL bp_rdata: got %h want 12345678", s_rdata); end
      @(negedge clk);
      drive_quiet();
      #1;
      total++; if (busy !== 1'b0 || grant !== 1'b1) begin bad++; $display("FAIL bp_end: got busy=%b grant=%0d want 0/1", busy, grant); end
      @(negedge clk);
   endtask

   task automatic test_error();
      s_arvalid = 2'b11;
      #1;
      total++; if (s_arready !== 2'b01) begin bad++; $display("FAIL err_arready0: got %b want 01", s_arready); end
      @(negedge clk);
      s_arvalid = 2'b00; m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b1; m_rresp = RESP_SLVERR; m_rdata = 32'hBAD0_0001; s_rready = 2'b01;
      #1;
      total++; if (s_rresp !== RESP_SLVERR) begin bad++; $display("FAIL err_slverr: got %0d want 2", s_rresp); end
      total++; if (s_rvalid !== 2'b01) begin bad++; $display("FAIL err_rvalid0: got %b want 01", s_rvalid); end
      @(negedge clk);
      drive_quiet(); s_arvalid = 2'b11;
      #1;
      total++; if (s_arready !== 2'b10) begin bad++; $display("FAIL err_ptr_adv: got %b want 10", s_arready); end
      @(negedge clk);
      s_arvalid = 2'b00; m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b1; m_rresp = RESP_DECERR; s_rready = 2'b10;
      #1;
      total++; if (s_rresp !== RESP_DECERR) begin bad++; $display("FAIL err_decerr: got %0d want 3", s_rresp); end
      total++; if (s_rvalid !== 2'b10) begin bad++; $display("FAIL err_rvalid1: got %b want 10", s_rvalid); end
      @(negedge clk);
      drive_quiet();
   endtask

   task automatic test_reset_in_ar();
      s_arvalid = 2'b10;
      @(negedge clk);
      s_arvalid = 2'b00;
      #1;
      total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL rst_ar_pre: got %b want 1", m_arvalid); end
      #1 axi_arstn = 1'b0;
      #1;
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_ar_arvalid: got %b want 0", m_arvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_ar_busy: got %b want 0", busy); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL rst_ar_grant: got %0d want 0", grant); end
      @(negedge clk);
      axi_arstn = 1'b1; s_arvalid = 2'b11;
      #1;
      total++; if (s_arready !== 2'b01) begin bad++; $display("FAIL rst_ar_first: got %b want 01", s_arready); end
      @(negedge clk);
      s_arvalid = 2'b00; m_arready = 1'b1;
      #1;
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL rst_ar_grant0: got %0d want 0", grant); end
      @(negedge clk);
      m_arready = 1'b0; m_rvalid = 1'b1; s_rready = 2'b01;
      @(negedge clk);
      drive_quiet();
   endtask

   // Random traffic against a transaction-level model: the model only knows
   // whether a transaction is waiting for its address or its data, who owns
   // it, and who was served last.
   task automatic test_random();
      int last = N - 1, own = 0, phase = 0, ntx = 0, cyc = 0, win;
      logic [0:0]    exp_grant = 1'b0;
      logic [AW-1:0] exp_addr = '0;
      logic [2:0]    exp_prot = '0;
      logic [1:0]    exp_oh;
      do_reset();
      while (ntx < 150 && cyc < 4000) begin
         s_arvalid = 2'($urandom_range(0, 3));
         s_araddr  = {$urandom, $urandom};
         s_arprot  = 6'($urandom);
         m_arready = ($urandom_range(0, 2) == 0);
         m_rvalid  = ($urandom_range(0, 1) == 1);
         m_rdata   = $urandom;
         m_rresp   = 2'($urandom);
         s_rready  = 2'($urandom);
         #1;
         if (phase == 0) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
               if (win < 0 && s_arvalid[(last + k) % N]) win = (last + k) % N;
            end
            exp_oh = (win < 0) ? 2'b00 : 2'(1 << win);
            total++; if (s_arready !== exp_oh) begin bad++; $display("FAIL rnd_arready@%0d: got %b want %b", cyc, s_arready, exp_oh); end
            total++; if (busy !== 1'b0 || m_arvalid !== 1'b0) begin bad++; $display("FAIL rnd_idle@%0d: got busy=%b arvalid=%b want 0/0", cyc, busy, m_arvalid); end
            total++; if (m_rready !== 1'b0 || s_rvalid !== 2'b00) begin bad++; $display("FAIL rnd_idle_r@%0d: got rready=%b rvalid=%b", cyc, m_rready, s_rvalid); end
            total++; if (grant !== exp_grant) begin bad++; $display("FAIL rnd_idle_grant@%0d: got %0d want %0d", cyc, grant, exp_grant); end
            if (win >= 0) begin
               own = win; exp_grant = 1'(win);
               exp_addr = s_araddr[own*AW +: AW];
               exp_prot = s_arprot[own*3 +: 3];
               phase = 1;
            end
         end else if (phase == 1) begin
            total++; if (m_arvalid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rnd_ar@%0d: got arvalid=%b busy=%b want 1/1", cyc, m_arvalid, busy); end
            total++; if (m_araddr !== exp_addr || m_arprot !== exp_prot) begin bad++; $display("FAIL rnd_araddr@%0d: got %h/%b want %h/%b", cyc, m_araddr, m_arprot, exp_addr, exp_prot); end
            total++; if (grant !== exp_grant) begin bad++; $display("FAIL rnd_ar_grant@%0d: got %0d want %0d", cyc, grant, exp_grant); end
            total++; if (s_arready !== 2'b00 || m_rready !== 1'b0 || s_rvalid !== 2'b00) begin bad++; $display("FAIL rnd_ar_quiet@%0d: got arready=%b rready=%b rvalid=%b", cyc, s_arready, m_rready, s_rvalid); end
            if (m_arready) phase = 2;
         end else begin
            exp_oh = m_rvalid ? 2'(1 << own) : 2'b00;
            total++; if (s_rvalid !== exp_oh) begin bad++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, s_rvalid, exp_oh); end
            total++; if (m_rready !== s_rready[own]) begin bad++; $display("FAIL rnd_rready@%0d: got %b want %b", cyc, m_rready, s_rready[own]); end
            total++; if (s_rdata !== m_rdata || s_rresp !== m_rresp) begin bad++; $display("FAIL rnd_rdata@%0d: got %h/%0d want %h/%0d", cyc, s_rdata, s_rresp, m_rdata, m_rresp); end
            total++; if (s_arready !== 2'b00 || m_arvalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rnd_r_state@%0d: got arready=%b arvalid=%b busy=%b", cyc, s_arready, m_arvalid, busy); end
            if (m_rvalid && s_rready[own]) begin
               last = own; phase = 0; ntx++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      total++; if (ntx < 150) begin bad++; $display("FAIL rnd_timeout: got %0d transactions want 150", ntx); end
      drive_quiet();
   endtask

   initial begin
      axi_arstn = 1'b0;
      drive_quiet();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_error();
      test_reset_in_ar();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_rd_arbiter.md
AXI_LITE_RD_ARBITER -- requirements
Module: axi_lite_rd_arbiter

Interface
REQ-001 SHALL have parameter N, default 2, meaning number of read requesters (0 = data port, 1 = instruction fetch).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AXI-Lite address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning AXI-Lite data width; GW = max(1, clog2(N)).
REQ-004 SHALL have port axi_aclk, input, 1, meaning single clock; all logic is rising-edge.
REQ-005 SHALL have port axi_arstn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port s_arvalid, input, N, meaning per-requester AR valid.
REQ-007 SHALL have port s_arready, output, N, meaning per-requester AR ready.
REQ-008 SHALL have port s_araddr, input, N*ADDR_W, meaning requester i address in slice i.
REQ-009 SHALL have port s_arprot, input, N*3, meaning requester i prot in slice i.
REQ-010 SHALL have port s_rvalid, output, N, meaning per-requester R valid.
REQ-011 SHALL have port s_rready, input, N, meaning per-requester R ready.
REQ-012 SHALL have port s_rdata, output, DATA_W, meaning read data broadcast to all requesters.
REQ-013 SHALL have port s_rresp, output, 2, meaning read response broadcast to all requesters.
REQ-014 SHALL have ports m_arvalid (output, 1), m_arready (input, 1), m_araddr (output, ADDR_W), m_arprot (output, 3), meaning shared downstream AR channel.
REQ-015 SHALL have ports m_rvalid (input, 1), m_rready (output, 1), m_rdata (input, DATA_W), m_rresp (input, 2), meaning shared downstream R channel.
REQ-016 SHALL have port grant, output, GW, meaning index of current/last owner.
REQ-017 SHALL have port busy, output, 1, meaning a transaction is in flight (state != IDLE).

Function
REQ-018 SHALL implement FSM IDLE -> AR -> R -> IDLE, with one outstanding transaction.
REQ-019 In IDLE with any s_arvalid set, SHALL pick a winner by round-robin: search from ptr+1 upward, wrapping modulo N.
REQ-020 SHALL assert s_arready[winner] combinationally in IDLE only; all other s_arready bits SHALL be 0.
REQ-021 On the IDLE handshake, SHALL register the winner's address, prot and index into grant, then enter AR.
REQ-022 In AR, SHALL drive m_arvalid=1 with registered address and prot held stable; m_arvalid SHALL NOT drop before m_arready; on m_arready, SHALL enter R.
REQ-023 In R, SHALL drive s_rvalid[grant]=m_rvalid and m_rready=s_rready[grant]; all other s_rvalid bits SHALL be 0.
REQ-024 In IDLE and AR, m_rready SHALL be 0.
REQ-025 s_rdata/s_rresp SHALL pass m_rdata/m_rresp through combinationally; requesters qualify them with s_rvalid.
REQ-026 On the R handshake, SHALL set ptr to grant and return to IDLE; minimum transaction time is 3 cycles.
REQ-027 SHALL leave a requester that deasserts s_arvalid before being granted ungranted, with no state change.
REQ-028 If all N requesters are valid continuously, SHALL grant each exactly once per N transactions.
REQ-029 SHALL forward SLVERR/DECERR responses unmodified to the owner.

Reset
REQ-030 On axi_arstn low, SHALL asynchronously set state=IDLE, ptr=N-1 (requester 0 wins first), grant=0, registered addr/prot=0, m_arvalid=0, busy=0.
REQ-031 Assertion mid-transaction SHALL abandon the transaction; the downstream slave SHALL share the same reset.

Structure
REQ-032 Package axi_lite_arb_pkg SHALL hold the FSM state enum, RESP constants (OKAY=0, SLVERR=2, DECERR=3) and the GW width function.
REQ-033 Combinational round-robin picker SHALL be sub-module rr_pick (inputs req[N], ptr; outputs any, idx).

Verification
REQ-034 Single request: s_arvalid=01, addr 0x0000_0010, slave rdata 0xDEAD_BEEF with 0-cycle latency -> s_arready[0] in cycle 0, m_arvalid in cycle 1, s_rvalid[0] with 0xDEAD_BEEF in cycle 2, grant=0.
REQ-035 Contention: s_arvalid=11 held over 4 transactions -> grant sequence 0,1,0,1 after reset.
REQ-036 Backpressure: m_arready low 5 cycles, s_rready[1] low 3 cycles -> m_araddr stable, m_arvalid held, no data loss, s_rvalid[0]=0 throughout.
REQ-037 Error: slave returns rresp=2 -> owner sees s_rresp=2, ptr advances normally.
REQ-038 Reset in AR state -> m_arvalid=0, busy=0 immediately; first request after release grants requester 0.
